// File: rtl/ex_data_fifo_rd_packer.sv
// ex_data_fifo_rd_packer
// Drains bytes from a show-ahead FIFO and packs them little-endian into
// words on a valid/ready output port. A flush pulse closes the current
// frame, either by emitting a partial word or by tagging the word that is
// already waiting on the output, and marks that word as the frame's last.
module ex_data_fifo_rd_packer #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         fifo_rd_en,
  input  logic                         fifo_rd_vld,
  input  logic [BYTE_W-1:0]            fifo_rd_data,
  input  logic                         flush,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [BYTE_W*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]        out_keep,
  output logic                         out_last,
  output logic [CNT_W-1:0]             word_cnt
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

  // Architectural state
  logic [WORD_W-1:0]     acc;
  logic [IDX_W-1:0]      idx;
  logic                  flush_pend;

  // Next-state values
  logic [WORD_W-1:0]     acc_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  flush_pend_nxt;
  logic                  out_vld_nxt;
  logic [WORD_W-1:0]     out_data_nxt;
  logic [WORD_BYTES-1:0] out_keep_nxt;
  logic                  out_last_nxt;
  logic [CNT_W-1:0]      word_cnt_nxt;

  // Intermediate values: assembly state after this cycle's byte, if any
  logic                  out_free;
  logic                  at_last;
  logic                  pop;
  logic                  close_req;
  logic                  held_word;
  logic [WORD_W-1:0]     acc_b;
  logic [IDX_W-1:0]      idx_b;
  logic                  word_full;
  logic [WORD_W-1:0]     part_data;
  logic [WORD_BYTES-1:0] part_keep;

  // The output register can take a new word when it is empty or being
  // drained this cycle; a word "held" is one that stays put this cycle.
  assign out_free  = !out_vld | out_rdy;
  assign held_word = out_vld & !out_rdy;
  assign at_last   = (idx == IDX_LAST);

  // Pop whenever a byte is available, unless a close is pending or the
  // byte would complete a word that has nowhere to go. No path from data.
  assign fifo_rd_en = fifo_rd_vld & !rst & !flush_pend & !(at_last & !out_free);
  assign pop        = fifo_rd_en & fifo_rd_vld;

  // A new flush is folded into a pending one; both mean "close the frame".
  assign close_req  = flush | flush_pend;

  // Merge this cycle's byte (if popped) into the assembly register.
  always_comb begin
    acc_b     = acc;
    idx_b     = idx;
    word_full = 1'b0;
    if (pop) begin
      acc_b[idx*BYTE_W +: BYTE_W] = fifo_rd_data;
      if (at_last) begin
        idx_b     = '0;
        word_full = 1'b1;
      end else begin
        idx_b     = idx + 1'b1;
      end
    end
  end

  // Build the partial word: bytes below idx_b are valid, the rest are zero.
  always_comb begin
    part_data = '0;
    part_keep = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (i < int'(idx_b)) begin
        part_keep[i]                 = 1'b1;
        part_data[i*BYTE_W +: BYTE_W] = acc_b[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Next-state logic: word completion, flush servicing and word counting.
  always_comb begin
    acc_nxt        = acc_b;
    idx_nxt        = idx_b;
    flush_pend_nxt = flush_pend;
    out_vld_nxt    = held_word;
    out_data_nxt   = out_data;
    out_keep_nxt   = out_keep;
    out_last_nxt   = out_last;
    word_cnt_nxt   = word_cnt + CNT_W'(out_vld & out_rdy);

    // A completed word always finds the output free (pop rule guarantees it).
    if (word_full) begin
      out_vld_nxt  = 1'b1;
      out_data_nxt = acc_b;
      out_keep_nxt = '1;
      out_last_nxt = 1'b0;
    end

    if (close_req) begin
      if (idx_b != '0) begin
        // Bytes are left over: ship them as a short last word once the
        // output register is free, otherwise stop popping and wait.
        if (out_free) begin
          out_vld_nxt    = 1'b1;
          out_data_nxt   = part_data;
          out_keep_nxt   = part_keep;
          out_last_nxt   = 1'b1;
          idx_nxt        = '0;
          flush_pend_nxt = 1'b0;
        end else begin
          flush_pend_nxt = 1'b1;
        end
      end else begin
        // Word boundary: tag the fresh or still-waiting word as last; with
        // nothing in the output register the flush is simply dropped.
        if (word_full || held_word) begin
          out_last_nxt = 1'b1;
        end
        flush_pend_nxt = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; a reset discards any bytes
  // already assembled but leaves the FIFO itself alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      idx        <= '0;
      flush_pend <= 1'b0;
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      word_cnt   <= '0;
    end else begin
      acc        <= acc_nxt;
      idx        <= idx_nxt;
      flush_pend <= flush_pend_nxt;
      out_vld    <= out_vld_nxt;
      out_data   <= out_data_nxt;
      out_keep   <= out_keep_nxt;
      out_last   <= out_last_nxt;
      word_cnt   <= word_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ex_data_fifo_rd_packer.sv
// Testbench for ex_data_fifo_rd_packer: a table of per-cycle vectors for
// reset, idle and streaming, followed by hand-written sequences driven from
// a small FIFO model for backpressure and the flush corner cases.
module tb_ex_data_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rd_en;
  logic        fifo_rd_vld;
  logic [7:0]  fifo_rd_data;
  logic        flush;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic [15:0] word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: bytes in fifo_mem[head..tail-1], head byte shown ahead
  logic [7:0] fifo_mem [0:127];
  int head  = 0;
  int tail  = 0;
  int pops  = 0;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic        flush;
    logic        rdy;
    logic        exp_en;
    logic        exp_vld;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [13];

  ex_data_fifo_rd_packer #(
    .BYTE_W(8),
    .WORD_BYTES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_data(fifo_rd_data),
    .flush(flush),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .out_data(out_data),
    .out_keep(out_keep),
    .out_last(out_last),
    .word_cnt(word_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    fifo_rd_vld  = v.vld;
    fifo_rd_data = v.data;
    flush        = v.flush;
    out_rdy      = v.rdy;
  endtask

  task automatic driveFifo();
    if (head < tail) begin
      fifo_rd_vld  = 1'b1;
      fifo_rd_data = fifo_mem[head];
    end else begin
      fifo_rd_vld  = 1'b0;
      fifo_rd_data = 8'h00;
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifo_mem[tail] = b;
    tail++;
    driveFifo();
  endtask

  // One clock cycle with the FIFO model popping on rd_en & rd_vld
  task automatic tick();
    logic en_s;
    logic vld_s;
    @(negedge clk);
    en_s  = fifo_rd_en;
    vld_s = fifo_rd_vld;
    @(posedge clk);
    if (en_s && vld_s) begin
      head++;
      pops++;
    end
    #1;
    driveFifo();
  endtask

  task automatic resetDut();
    rst     = 1'b1;
    flush   = 1'b0;
    head    = tail;
    driveFifo();
    tick();
    tick();
    rst  = 1'b0;
    pops = 0;
  endtask

  initial begin
    logic stable;

    // Reset and idle, then stream 0x01..0x08 with out_rdy high
    vecs[0]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b0, 16'd1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd2};

    rst          = 1'b1;
    fifo_rd_vld  = 1'b0;
    fifo_rd_data = 8'h00;
    flush        = 1'b0;
    out_rdy      = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 13; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d rd_en", k), 32'(fifo_rd_en), 32'(vecs[k].exp_en));
      checkOutput($sformatf("vec%0d out_vld", k), 32'(out_vld), 32'(vecs[k].exp_vld));
      checkOutput($sformatf("vec%0d word_cnt", k), 32'(word_cnt), 32'(vecs[k].exp_cnt));
      if (vecs[k].chk_data) begin
        checkOutput($sformatf("vec%0d out_data", k), out_data, vecs[k].exp_data);
        checkOutput($sformatf("vec%0d out_keep", k), 32'(out_keep), 32'(vecs[k].exp_keep));
        checkOutput($sformatf("vec%0d out_last", k), 32'(out_last), 32'(vecs[k].exp_last));
      end
      @(posedge clk);
      #1;
    end

    // Backpressure: 7 pops, first word held stable, then next word follows
    $display("[TB] backpressure sequence");
    resetDut();
    out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) pushByte(8'(8'h10 + i));
    repeat (4) tick();
    checkOutput("bp first vld", 32'(out_vld), 32'd1);
    checkOutput("bp first data", out_data, 32'h13121110);
    stable = 1'b1;
    repeat (8) begin
      tick();
      if (out_data !== 32'h13121110 || out_vld !== 1'b1) stable = 1'b0;
    end
    checkOutput("bp held stable", 32'(stable), 32'd1);
    checkOutput("bp pop count", 32'(pops), 32'd7);
    #1;
    checkOutput("bp stalled rd_en", 32'(fifo_rd_en), 32'd0);
    out_rdy = 1'b1;
    tick();
    checkOutput("bp next data", out_data, 32'h17161514);
    checkOutput("bp next keep", 32'(out_keep), 32'hF);
    checkOutput("bp word_cnt", 32'(word_cnt), 32'd1);
    checkOutput("bp pop count 2", 32'(pops), 32'd8);

    // Partial flush together with the accept of the third byte
    $display("[TB] partial flush sequence");
    resetDut();
    out_rdy = 1'b1;
    pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC); pushByte(8'hDD);
    pushByte(8'hEE); pushByte(8'hFF); pushByte(8'h11);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("pf pops", 32'(pops), 32'd3);
    checkOutput("pf vld", 32'(out_vld), 32'd1);
    checkOutput("pf data", out_data, 32'h00CCBBAA);
    checkOutput("pf keep", 32'(out_keep), 32'h7);
    checkOutput("pf last", 32'(out_last), 32'd1);
    #1;
    checkOutput("pf resume rd_en", 32'(fifo_rd_en), 32'd1);
    repeat (4) tick();
    checkOutput("pf next data", out_data, 32'h11FFEEDD);
    checkOutput("pf next keep", 32'(out_keep), 32'hF);
    checkOutput("pf next last", 32'(out_last), 32'd0);
    checkOutput("pf word_cnt", 32'(word_cnt), 32'd1);

    // Flush on a word boundary while a full word is held
    $display("[TB] boundary flush sequence");
    resetDut();
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) pushByte(8'(8'h21 + i));
    repeat (6) tick();
    checkOutput("bf held data", out_data, 32'h24232221);
    checkOutput("bf held last", 32'(out_last), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("bf last set", 32'(out_last), 32'd1);
    checkOutput("bf vld", 32'(out_vld), 32'd1);
    checkOutput("bf data kept", out_data, 32'h24232221);
    out_rdy = 1'b1;
    tick();
    checkOutput("bf accepted cnt", 32'(word_cnt), 32'd1);
    repeat (4) tick();
    checkOutput("bf no extra word", 32'(out_vld), 32'd0);

    // Flush with a partial word while the output is busy: pend until free
    $display("[TB] pending flush sequence");
    out_rdy = 1'b0;
    for (int i = 0; i < 6; i++) pushByte(8'(8'h31 + i));
    repeat (8) tick();
    checkOutput("pd pops", 32'(pops), 32'd10);
    checkOutput("pd held data", out_data, 32'h34333231);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pushByte(8'h37);
    repeat (2) tick();
    checkOutput("pd popping stopped", 32'(pops), 32'd10);
    checkOutput("pd held last", 32'(out_last), 32'd0);
    checkOutput("pd held data 2", out_data, 32'h34333231);
    out_rdy = 1'b1;
    tick();
    checkOutput("pd partial data", out_data, 32'h00003635);
    checkOutput("pd partial keep", 32'(out_keep), 32'h3);
    checkOutput("pd partial last", 32'(out_last), 32'd1);
    checkOutput("pd word_cnt", 32'(word_cnt), 32'd2);
    #1;
    checkOutput("pd resume rd_en", 32'(fifo_rd_en), 32'd1);
    tick();
    checkOutput("pd pops resumed", 32'(pops), 32'd11);

    // Empty flush is dropped; reset mid-word discards popped bytes
    $display("[TB] empty flush and mid-word reset sequence");
    resetDut();
    out_rdy = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    checkOutput("ef no word", 32'(out_vld), 32'd0);
    checkOutput("ef word_cnt", 32'(word_cnt), 32'd0);
    pushByte(8'h41); pushByte(8'h42);
    pushByte(8'h51); pushByte(8'h52); pushByte(8'h53); pushByte(8'h54);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checkOutput("mr rd_en in reset", 32'(fifo_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    checkOutput("mr pops", 32'(pops), 32'd2);
    checkOutput("mr vld after reset", 32'(out_vld), 32'd0);
    for (int cyc = 0; cyc < 10 && out_vld !== 1'b1; cyc++) tick();
    checkOutput("mr clean word vld", 32'(out_vld), 32'd1);
    checkOutput("mr clean word data", out_data, 32'h54535251);
    checkOutput("mr clean word keep", 32'(out_keep), 32'hF);
    checkOutput("mr clean word last", 32'(out_last), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
